// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in (valid/ready) and instruction memory write out
interface imem_loader_if #(
  parameter int ADDR_W = 7
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  modport master (output in_valid, in_data, input in_ready, im_we, im_addr, im_wdata);
  modport slave  (input in_valid, in_data, output in_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader turning a big-endian byte stream into imem writes (clk, rst_n async low, bus stream/write, restart_i, cpu_hold_o, done_o, err_o; optional IMEM_LOADER_CKSUM_EN)
module imem_loader #(
  parameter int ADDR_W    = 7,
  parameter int MAX_WORDS = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus,
  input  logic          restart_i,
  output logic          cpu_hold_o,
  output logic          done_o,
  output logic          err_o
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [1:0] S_HDR = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2, S_ERR = 2'd3;
  logic [1:0]        state_q, state_d, idx_q, idx_d;
  logic [23:0]       part_q, part_d;
  logic [CW-1:0]     cnt_q, cnt_d, n_q, n_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, word;
  logic              hs, last;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif
  assign hs   = bus.in_valid & bus.in_ready;
  assign last = hs && idx_q == 2'd3;
  assign word = {part_q, bus.in_data};
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CKSUM_EN
    csum_d  = csum_q;
`endif
    if (hs) begin
      idx_d  = idx_q + 2'd1;
      part_d = {part_q[15:0], bus.in_data};
    end
    if (state_q == S_HDR && last) begin
      n_d   = word[CW-1:0];
      cnt_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
      csum_d  = word;
      state_d = word > 32'(MAX_WORDS) ? S_ERR : S_LOAD;
`else
      state_d = word == 32'd0 ? S_DONE : word > 32'(MAX_WORDS) ? S_ERR : S_LOAD;
`endif
    end
    if (state_q == S_LOAD && last) begin
`ifdef IMEM_LOADER_CKSUM_EN
      // once all data words are in, the next group is the checksum, never written
      if (cnt_q == n_q) state_d = word == csum_q ? S_DONE : S_ERR;
      else begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(cnt_q);
        wdata_d = word;
        cnt_d   = cnt_q + CW'(1);
        csum_d  = csum_q ^ word;
      end
`else
      we_d    = 1'b1;
      addr_d  = ADDR_W'(cnt_q);
      wdata_d = word;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q + CW'(1) == n_q) state_d = S_DONE;
`endif
    end
    if ((state_q == S_DONE || state_q == S_ERR) && restart_i) begin
      state_d = S_HDR;
      idx_d   = '0;
      part_d  = '0;
      cnt_d   = '0;
      n_d     = '0;
      addr_d  = '0;
      wdata_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
      csum_d  = '0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR;
      idx_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  assign bus.in_ready = state_q == S_HDR || state_q == S_LOAD;
  assign bus.im_we    = we_q;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign cpu_hold_o   = state_q != S_DONE;
  assign done_o       = state_q == S_DONE;
  assign err_o        = state_q == S_ERR;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart_i = 1'b0;
  logic cpu_hold_o, done_o, err_o;
  int errors = 0;
  int checks = 0;
  int wn = 0;
  logic [6:0]  wa [0:15];
  logic [31:0] wd [0:15];
  imem_loader_if #(.ADDR_W(7)) bus();
  imem_loader #(.ADDR_W(7), .MAX_WORDS(128)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .restart_i(restart_i),
    .cpu_hold_o(cpu_hold_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.im_we && wn < 16) begin
    wa[wn] = bus.im_addr;
    wd[wn] = bus.im_wdata;
    wn = wn + 1;
  end
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: in_ready=%b want 1", bus.in_ready);
    end
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask
  task automatic end_stream();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
  endtask
  task automatic pulse_restart();
    @(negedge clk);
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    #2;
  endtask
  task automatic test_reset();
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.im_we !== 1'b0) begin errors++; $display("FAIL rst_im_we: got %b want 0", bus.im_we); end
    checks++; if (bus.im_addr !== 7'd0) begin errors++; $display("FAIL rst_im_addr: got %h want 0", bus.im_addr); end
    checks++; if (bus.im_wdata !== 32'd0) begin errors++; $display("FAIL rst_im_wdata: got %h want 0", bus.im_wdata); end
    checks++; if (cpu_hold_o !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    wn = 0;
    send_word(32'd2);
    send_word(32'h00411822);
    send_word(32'h00000020);
    end_stream();
    checks++; if (wn !== 2) begin errors++; $display("FAIL basic_wr_count: got %0d want 2", wn); end
    checks++; if (wa[0] !== 7'd0 || wd[0] !== 32'h00411822) begin errors++; $display("FAIL basic_wr0: got %h/%h want 00/00411822", wa[0], wd[0]); end
    checks++; if (wa[1] !== 7'd1 || wd[1] !== 32'h00000020) begin errors++; $display("FAIL basic_wr1: got %h/%h want 01/00000020", wa[1], wd[1]); end
    checks++; if ({done_o, cpu_hold_o, bus.in_ready} !== 3'b100) begin errors++; $display("FAIL basic_status: got done/hold/ready=%b want 100", {done_o, cpu_hold_o, bus.in_ready}); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (wn !== 2) begin errors++; $display("FAIL basic_no_more_writes: got %0d want 2", wn); end
    pulse_restart();
    checks++; if ({done_o, cpu_hold_o, bus.in_ready} !== 3'b011) begin errors++; $display("FAIL basic_restart: got done/hold/ready=%b want 011", {done_o, cpu_hold_o, bus.in_ready}); end
  endtask
  task automatic test_gaps();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    wn = 0;
    send_word(32'd1);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      if (i != 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.im_we !== 1'b0) begin errors++; $display("FAIL gaps_early_we: got %b want 0", bus.im_we); end
      end
    end
    end_stream();
    checks++; if (bus.im_we !== 1'b1 || bus.im_addr !== 7'd0 || bus.im_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL gaps_write: got we=%b %h/%h want 1 00/deadbeef", bus.im_we, bus.im_addr, bus.im_wdata); end
    @(negedge clk);
    #1;
    checks++; if (wn !== 1 || done_o !== 1'b1) begin errors++; $display("FAIL gaps_single: got wn=%0d done=%b want 1 1", wn, done_o); end
    pulse_restart();
  endtask
  task automatic test_overflow();
    wn = 0;
    send_word(32'h00000081);
    end_stream();
    checks++; if ({err_o, cpu_hold_o, bus.in_ready, done_o} !== 4'b1100) begin errors++; $display("FAIL ovf_status: got err/hold/ready/done=%b want 1100", {err_o, cpu_hold_o, bus.in_ready, done_o}); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (wn !== 0) begin errors++; $display("FAIL ovf_writes: got %0d want 0", wn); end
    pulse_restart();
    checks++; if (err_o !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL ovf_restart: got err=%b ready=%b want 0 1", err_o, bus.in_ready); end
  endtask
  task automatic test_async_reset();
    wn = 0;
    send_word(32'd4);
    send_word(32'h11111111);
    send_word(32'h22222222);
    end_stream();
    checks++; if (bus.im_we !== 1'b1 || bus.im_addr !== 7'd1) begin errors++; $display("FAIL arst_pre: got we=%b addr=%h want 1 01", bus.im_we, bus.im_addr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.im_we !== 1'b0 || bus.im_addr !== 7'd0 || bus.im_wdata !== 32'd0) begin errors++; $display("FAIL arst_bus: got we=%b %h/%h want 0 00/0", bus.im_we, bus.im_addr, bus.im_wdata); end
    checks++; if ({bus.in_ready, cpu_hold_o, done_o, err_o} !== 4'b1100) begin errors++; $display("FAIL arst_status: got ready/hold/done/err=%b want 1100", {bus.in_ready, cpu_hold_o, done_o, err_o}); end
    @(negedge clk);
    rst_n = 1'b1;
    wn = 0;
    send_word(32'd1);
    send_word(32'h12345678);
    end_stream();
    checks++; if (bus.im_we !== 1'b1 || bus.im_addr !== 7'd0 || bus.im_wdata !== 32'h12345678 || done_o !== 1'b1) begin errors++; $display("FAIL arst_reload: got we=%b %h/%h done=%b want 1 00/12345678 1", bus.im_we, bus.im_addr, bus.im_wdata, done_o); end
    pulse_restart();
  endtask
  task automatic test_zero();
    wn = 0;
    send_word(32'd0);
    end_stream();
    checks++; if (done_o !== 1'b1 || bus.in_ready !== 1'b0 || cpu_hold_o !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b ready=%b hold=%b want 1 0 0", done_o, bus.in_ready, cpu_hold_o); end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0 || wn !== 0) begin errors++; $display("FAIL zero_extra: got ready=%b wn=%0d want 0 0", bus.in_ready, wn); end
    bus.in_valid = 1'b0;
    pulse_restart();
  endtask
  task automatic test_cksum();
    wn = 0;
    send_word(32'd1);
    send_word(32'h00000020);
    send_word(32'h00000021);
    end_stream();
    checks++; if (done_o !== 1'b1 || err_o !== 1'b0 || wn !== 1) begin errors++; $display("FAIL cksum_good: got done=%b err=%b wn=%0d want 1 0 1", done_o, err_o, wn); end
    pulse_restart();
    wn = 0;
    send_word(32'd1);
    send_word(32'h00000020);
    send_word(32'h00000000);
    end_stream();
    checks++; if (err_o !== 1'b1 || done_o !== 1'b0 || wn !== 1 || wa[0] !== 7'd0) begin errors++; $display("FAIL cksum_bad: got err=%b done=%b wn=%0d addr=%h want 1 0 1 00", err_o, done_o, wn, wa[0]); end
    pulse_restart();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
`ifdef IMEM_LOADER_CKSUM_EN
    test_cksum();
`else
    test_basic();
    test_gaps();
    test_overflow();
    test_async_reset();
    test_zero();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
